// File: rtl/alu_issue_stage.sv
// alu_issue_stage: execute-issue stage in front of the 32-bit ALU.
// Accepts one data-processing instruction per handshake and checks its condition
// against the architectural NZCV flags, which this block owns. It drives the ALU
// operands and controls for SETTLE_CYCLES cycles, then samples the result and flags
// and offers a writeback transaction. Instructions never overlap.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready      instruction handshake; in_cond/opcode/s/rd/op1/op2 payload
//   alu_a/alu_b            ALU operands
//   alu_invert_a/_b        operand inversion
//   alu_is_logic           logic path select
//   alu_logic_func_idx     00 AND, 01 ORR, 10 EOR
//   alu_cin                adder carry-in
//   alu_isactive           ALU enable
//   alu_result/alu_n/z/c/v ALU outputs
//   wb_valid/wb_ready      writeback handshake; wb_en/wb_rd/wb_data payload
//   flags                  architectural {N,Z,C,V}
//
// Optional feature: define ALU_ISSUE_PERF_EN to add the saturating exec_count and
// skip_count performance counters.

module alu_issue_stage #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_cond,
  input  logic [3:0]  in_opcode,
  input  logic        in_s,
  input  logic [3:0]  in_rd,
  input  logic [31:0] in_op1,
  input  logic [31:0] in_op2,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_invert_a,
  output logic        alu_invert_b,
  output logic        alu_is_logic,
  output logic [1:0]  alu_logic_func_idx,
  output logic        alu_cin,
  output logic        alu_isactive,
  input  logic [31:0] alu_result,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_c,
  input  logic        alu_v,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic        wb_en,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
`ifdef ALU_ISSUE_PERF_EN
  output logic [15:0] exec_count,
  output logic [15:0] skip_count,
`endif
  output logic [3:0]  flags
);

  localparam int unsigned CNT_W = 4;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             q_s;
  logic             q_test;
  logic             q_logic;
  logic             q_wen;

  // ARM condition evaluation against {N,Z,C,V}
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = !z;
      4'h2:    cond_pass = c;
      4'h3:    cond_pass = !c;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = !n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = !v;
      4'h8:    cond_pass = c && !z;
      4'h9:    cond_pass = !c || z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = !z && (n == v);
      4'hD:    cond_pass = z || (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // Opcode decode to ALU controls
  logic       d_logic;
  logic [1:0] d_func;
  logic       d_inv_a;
  logic       d_inv_b;
  logic       d_cin;
  logic       d_zero_a;
  logic       d_test;
  logic       d_pass;

  always_comb begin
    d_logic  = 1'b0;
    d_func   = 2'b00;
    d_inv_a  = 1'b0;
    d_inv_b  = 1'b0;
    d_cin    = 1'b0;
    d_zero_a = 1'b0;
    d_test   = 1'b0;
    case (in_opcode)
      OP_AND: d_logic = 1'b1;
      OP_EOR: begin d_logic = 1'b1; d_func = 2'b10; end
      OP_SUB: begin d_inv_b = 1'b1; d_cin = 1'b1; end
      OP_RSB: begin d_inv_a = 1'b1; d_cin = 1'b1; end
      OP_ADD: d_cin = 1'b0;
      OP_ADC: d_cin = flags[1];
      OP_SBC: begin d_inv_b = 1'b1; d_cin = flags[1]; end
      OP_RSC: begin d_inv_a = 1'b1; d_cin = flags[1]; end
      OP_TST: begin d_logic = 1'b1; d_test = 1'b1; end
      OP_TEQ: begin d_logic = 1'b1; d_func = 2'b10; d_test = 1'b1; end
      OP_CMP: begin d_inv_b = 1'b1; d_cin = 1'b1; d_test = 1'b1; end
      OP_CMN: d_test = 1'b1;
      OP_ORR: begin d_logic = 1'b1; d_func = 2'b01; end
      OP_MOV: d_zero_a = 1'b1;
      OP_BIC: begin d_logic = 1'b1; d_inv_b = 1'b1; end
      OP_MVN: begin d_zero_a = 1'b1; d_inv_b = 1'b1; end
      default: d_test = 1'b0;
    endcase
    d_pass = cond_pass(in_cond, flags);
  end

  // Issue FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      cnt                <= '0;
      q_s                <= 1'b0;
      q_test             <= 1'b0;
      q_logic            <= 1'b0;
      q_wen              <= 1'b0;
      in_ready           <= 1'b1;
      alu_a              <= '0;
      alu_b              <= '0;
      alu_invert_a       <= 1'b0;
      alu_invert_b       <= 1'b0;
      alu_is_logic       <= 1'b0;
      alu_logic_func_idx <= 2'b00;
      alu_cin            <= 1'b0;
      alu_isactive       <= 1'b0;
      wb_valid           <= 1'b0;
      wb_en              <= 1'b0;
      wb_rd              <= '0;
      wb_data            <= '0;
      flags              <= '0;
`ifdef ALU_ISSUE_PERF_EN
      exec_count         <= '0;
      skip_count         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            wb_rd    <= in_rd;
            if (d_pass) begin
              state              <= EXEC;
              cnt                <= CNT_W'(SETTLE_CYCLES - 1);
              q_s                <= in_s;
              q_test             <= d_test;
              q_logic            <= d_logic;
              q_wen              <= !d_test;
              alu_a              <= d_zero_a ? 32'd0 : in_op1;
              alu_b              <= in_op2;
              alu_invert_a       <= d_inv_a;
              alu_invert_b       <= d_inv_b;
              alu_is_logic       <= d_logic;
              alu_logic_func_idx <= d_func;
              alu_cin            <= d_cin;
              alu_isactive       <= 1'b1;
            end else begin
              // Skipped: respond immediately without touching the ALU or flags
              state    <= RESP;
              wb_valid <= 1'b1;
              wb_en    <= 1'b0;
              wb_data  <= '0;
`ifdef ALU_ISSUE_PERF_EN
              if (skip_count != 16'hFFFF) skip_count <= skip_count + 16'd1;
`endif
            end
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            state        <= RESP;
            alu_isactive <= 1'b0;
            wb_valid     <= 1'b1;
            wb_en        <= q_wen;
            wb_data      <= alu_result;
            // Logic ops keep C and V; arithmetic ops load all four
            if (q_s || q_test) begin
              if (q_logic) flags <= {alu_n, alu_z, flags[1], flags[0]};
              else         flags <= {alu_n, alu_z, alu_c, alu_v};
            end
`ifdef ALU_ISSUE_PERF_EN
            if (exec_count != 16'hFFFF) exec_count <= exec_count + 16'd1;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (wb_ready) begin
            state    <= IDLE;
            wb_valid <= 1'b0;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: a behavioural ALU answers the stage,
// and a reference model of the stage pushes expected writebacks to a scoreboard.
module tb_alu_issue_stage;

  localparam int unsigned SETTLE = 4;

  logic        clk;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_cond = '0;
  logic [3:0]  in_opcode = '0;
  logic        in_s = 1'b0;
  logic [3:0]  in_rd = '0;
  logic [31:0] in_op1 = '0;
  logic [31:0] in_op2 = '0;
  logic [31:0] alu_a, alu_b;
  logic        alu_invert_a, alu_invert_b, alu_is_logic, alu_cin, alu_isactive;
  logic [1:0]  alu_logic_func_idx;
  logic [31:0] alu_result;
  logic        alu_n, alu_z, alu_c, alu_v;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic        wb_en;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  flags;
`ifdef ALU_ISSUE_PERF_EN
  logic [15:0] exec_count, skip_count;
`endif

  alu_issue_stage #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cond(in_cond), .in_opcode(in_opcode), .in_s(in_s), .in_rd(in_rd),
    .in_op1(in_op1), .in_op2(in_op2),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_invert_a(alu_invert_a), .alu_invert_b(alu_invert_b),
    .alu_is_logic(alu_is_logic), .alu_logic_func_idx(alu_logic_func_idx),
    .alu_cin(alu_cin), .alu_isactive(alu_isactive),
    .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data),
`ifdef ALU_ISSUE_PERF_EN
    .exec_count(exec_count), .skip_count(skip_count),
`endif
    .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 32-bit ALU
  logic [31:0] ea, eb;
  logic [32:0] esum;
  always_comb begin
    ea    = alu_invert_a ? ~alu_a : alu_a;
    eb    = alu_invert_b ? ~alu_b : alu_b;
    esum  = {1'b0, ea} + {1'b0, eb} + 33'(alu_cin);
    alu_c = 1'b0;
    alu_v = 1'b0;
    if (alu_is_logic) begin
      case (alu_logic_func_idx)
        2'b00:   alu_result = ea & eb;
        2'b01:   alu_result = ea | eb;
        2'b10:   alu_result = ea ^ eb;
        default: alu_result = '0;
      endcase
    end else begin
      alu_result = esum[31:0];
      alu_c      = esum[32];
      alu_v      = (ea[31] == eb[31]) && (esum[31] != ea[31]);
    end
    alu_n = alu_result[31];
    alu_z = (alu_result == 32'd0);
  end

  typedef struct packed {
    logic        pass;
    logic        en;
    logic [3:0]  rd;
    logic [31:0] data;
    logic [3:0]  flags;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [3:0] mflags = '0;
  logic snap_inv_a, snap_inv_b, snap_cin, snap_logic;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {V, C, result}
  function automatic logic [33:0] add3(input logic [31:0] x, input logic [31:0] y, input logic ci);
    logic [32:0] t;
    t = {1'b0, x} + {1'b0, y} + 33'(ci);
    return {(x[31] == y[31]) && (t[31] != x[31]), t};
  endfunction

  function automatic exp_t model(input logic [3:0] cond, input logic [3:0] op, input logic s,
                                 input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] f);
    exp_t e;
    logic n, z, c, v, p, lg, tst;
    logic [31:0] r;
    {n, z, c, v} = f;
    case (cond)
      4'h0: p = z;          4'h1: p = !z;
      4'h2: p = c;          4'h3: p = !c;
      4'h4: p = n;          4'h5: p = !n;
      4'h6: p = v;          4'h7: p = !v;
      4'h8: p = c & !z;     4'h9: p = !c | z;
      4'hA: p = (n == v);   4'hB: p = (n != v);
      4'hC: p = !z & (n == v);
      4'hD: p = z | (n != v);
      4'hE: p = 1'b1;
      default: p = 1'b0;
    endcase
    e.pass = p; e.rd = rd; e.flags = f; e.en = 1'b0; e.data = '0;
    if (!p) return e;
    lg = 1'b0; tst = 1'b0; c = 1'b0; v = 1'b0; r = '0;
    case (op)
      4'h0: begin r = a & b; lg = 1'b1; end
      4'h1: begin r = a ^ b; lg = 1'b1; end
      4'h2: {v, c, r} = add3(a, ~b, 1'b1);
      4'h3: {v, c, r} = add3(b, ~a, 1'b1);
      4'h4: {v, c, r} = add3(a, b, 1'b0);
      4'h5: {v, c, r} = add3(a, b, f[1]);
      4'h6: {v, c, r} = add3(a, ~b, f[1]);
      4'h7: {v, c, r} = add3(b, ~a, f[1]);
      4'h8: begin r = a & b; lg = 1'b1; tst = 1'b1; end
      4'h9: begin r = a ^ b; lg = 1'b1; tst = 1'b1; end
      4'hA: begin {v, c, r} = add3(a, ~b, 1'b1); tst = 1'b1; end
      4'hB: begin {v, c, r} = add3(a, b, 1'b0); tst = 1'b1; end
      4'hC: begin r = a | b; lg = 1'b1; end
      4'hD: r = b;
      4'hE: begin r = a & ~b; lg = 1'b1; end
      default: r = ~b;
    endcase
    e.en = !tst;
    e.data = r;
    if (s || tst)
      e.flags = lg ? {r[31], r == 32'd0, f[1], f[0]} : {r[31], r == 32'd0, c, v};
    return e;
  endfunction

  // Issue one instruction, check latency/ALU activity/writeback, optionally stall wb_ready
  task automatic run_insn(input logic [3:0] cond, input logic [3:0] op, input logic s,
                          input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
    exp_t e;
    int lat, act;
    logic [31:0] d0;
    logic [3:0]  r0;
    e = model(cond, op, s, rd, a, b, mflags);
    mflags = e.flags;
    sb.push_back(e);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_cond = cond; in_opcode = op; in_s = s; in_rd = rd; in_op1 = a; in_op2 = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    snap_inv_a = alu_invert_a; snap_inv_b = alu_invert_b;
    snap_cin = alu_cin; snap_logic = alu_is_logic;
    lat = 1; act = 0;
    while (!wb_valid && lat < 64) begin
      if (alu_isactive) act++;
      @(negedge clk);
      lat++;
    end
    if (!wb_valid) check("wb_valid_timeout", 32'd0, 32'd1);
    e = sb.pop_front();
    check("latency", 32'(lat), e.pass ? 32'(SETTLE + 1) : 32'd1);
    check("active_cycles", 32'(act), e.pass ? 32'(SETTLE) : 32'd0);
    check("wb_en", 32'(wb_en), 32'(e.en));
    check("wb_rd", 32'(wb_rd), 32'(e.rd));
    if (e.pass) check("wb_data", wb_data, e.data);
    check("flags", 32'(flags), 32'(e.flags));
    d0 = wb_data; r0 = wb_rd;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(wb_valid), 32'd1);
      check("hold_data", wb_data, d0);
      check("hold_rd", 32'(wb_rd), 32'(r0));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    check("wb_valid_drop", 32'(wb_valid), 32'd0);
    check("in_ready_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic seen;
    // Reset
    #2 rst_n = 1'b0;
    #1;
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_active", 32'(alu_isactive), 32'd0);
    check("rst_wb_en", 32'(wb_en), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // SUB AL S=1 5-5
    run_insn(4'hE, 4'h2, 1'b1, 4'd3, 32'd5, 32'd5, 0);
    check("sub_inv_b", 32'(snap_inv_b), 32'd1);
    check("sub_cin", 32'(snap_cin), 32'd1);
    check("sub_flags", 32'(flags), 32'h6);

    // Z=1: ADD NE skipped
    run_insn(4'h1, 4'h4, 1'b1, 4'd4, 32'd1, 32'd2, 0);
    check("skip_flags", 32'(flags), 32'h6);

    // CMP 3,7 (S=0, test op still updates flags)
    run_insn(4'hE, 4'hA, 1'b0, 4'd5, 32'd3, 32'd7, 0);
    check("cmp_data", wb_data, 32'hFFFF_FFFC);
    check("cmp_flags", 32'(flags), 32'h8);

    // Preset C=1, then ADC uses cin=C
    run_insn(4'hE, 4'h2, 1'b1, 4'd6, 32'd5, 32'd1, 0);
    check("preset_c", 32'(flags), 32'h2);
    run_insn(4'hE, 4'h5, 1'b1, 4'd7, 32'hFFFF_FFFF, 32'd0, 0);
    check("adc_cin", 32'(snap_cin), 32'd1);

    // Writeback stall for 3 cycles
    run_insn(4'hE, 4'hC, 1'b0, 4'd8, 32'h0F0F_0000, 32'h0000_00F0, 3);

    // Logic op with S keeps C/V
    run_insn(4'hE, 4'h1, 1'b1, 4'd9, 32'h8000_0000, 32'd0, 0);
    check("eor_logic", 32'(snap_logic), 32'd1);

    // Cond 1111 never passes
    run_insn(4'hF, 4'h4, 1'b1, 4'd10, 32'd1, 32'd1, 0);

    // All opcodes, random operands, with and without S
    for (int op = 0; op < 16; op++)
      run_insn(4'hE, 4'(op), 1'b1, 4'(op), $urandom, $urandom, 0);
    for (int op = 0; op < 16; op++)
      run_insn(4'hE, 4'(op), 1'b0, 4'(15 - op), $urandom, $urandom, 0);

    // Every condition after a flag-setting compare of random operands
    for (int c = 0; c < 16; c++) begin
      run_insn(4'hE, 4'hA, 1'b0, 4'd0, $urandom, $urandom, 0);
      run_insn(4'(c), 4'h4, 1'b0, 4'd2, $urandom, $urandom, 0);
    end

    // Reset during EXEC cycle 2 drops the instruction
    run_insn(4'hE, 4'h2, 1'b1, 4'd1, 32'd5, 32'd5, 0);
    @(negedge clk);
    in_cond = 4'hE; in_opcode = 4'h4; in_s = 1'b1; in_rd = 4'd3;
    in_op1 = 32'hFFFF_FFFF; in_op2 = 32'd1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_active", 32'(alu_isactive), 32'd0);
    check("rst_mid_flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mflags = '0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | wb_valid;
    end
    check("rst_mid_no_wb", 32'(seen), 32'd0);
    check("rst_mid_flags_after", 32'(flags), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
